masked_sbox_sched: RTL and testbench
====================================

Name: masked_sbox_sched

Overview:
- Sequences one multi-byte, two-share (data/mask) word through a single shared, pipelined masked S-box instance, one byte per issue slot.
- Consumes one fresh 8-bit random byte per S-box call and collects the returned share bytes in order.
- Presents the finished word on a valid/ready output. Sits between the round datapath and the masked S-box core.

Parameters:
- NBYTES, 4, bytes per word; legal range 1..16; byte k occupies bits [8k:8k+7].
- LATENCY, 3, S-box input-to-output latency in cycles; must be at least 1.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  scheduler idle, can accept a word
- data_i  in  [0:8*NBYTES-1]  data share
- mask_i  in  [0:8*NBYTES-1]  mask share
- op_i  in  [0:1]  public operation select, latched at accept
- prd_i  in  [0:7]  fresh random byte
- prd_valid_i  in  1  random byte available
- prd_ready_o  out  1  random byte consumed this cycle when prd_valid_i is also high
- sbox_valid_o  out  1  S-box input slot valid
- sbox_data_o  out  [0:7]  byte data share to S-box
- sbox_mask_o  out  [0:7]  byte mask share to S-box
- sbox_op_o  out  [0:1]  latched op
- sbox_prd_o  out  [0:7]  random byte to S-box
- sbox_data_i  in  [0:7]  S-box output data share
- sbox_mask_i  in  [0:7]  S-box output mask share
- out_valid_o  out  1  result word valid
- out_ready_i  in  1  downstream accepts result
- data_o  out  [0:8*NBYTES-1]  result data share
- mask_o  out  [0:8*NBYTES-1]  result mask share
- busy_o  out  1  state is not IDLE

Behaviour:
- Reset is asynchronous and active-high. While rst_i is high: state is IDLE and all outputs are 0, except in_ready_o, which is 1. All internal registers (byte counters, valid pipe, captured shares) clear. A reset mid-word aborts the word; nothing partial is emitted.
- FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i & in_ready_o, latch data_i, mask_i and op_i; clear the issue and capture counters; go to ISSUE.
- ISSUE:
  - prd_ready_o = 1.
  - On each edge with prd_valid_i high, register byte[issue_cnt] of both shares onto sbox_data_o/sbox_mask_o, register prd_i onto sbox_prd_o, set sbox_valid_o = 1, and increment issue_cnt.
  - If prd_valid_i is low, issue a bubble: sbox_valid_o = 0 and sbox_data_o, sbox_mask_o, sbox_prd_o all driven to 0. Shares are never left on the S-box bus during a bubble.
  - Each random byte is used for exactly one issue and is never reused.
  - After byte NBYTES-1 is issued, go to DRAIN.
- Issue tracking: a LATENCY-deep shift register carries each issue's valid bit. When a valid bit exits, capture sbox_data_i/sbox_mask_i into result byte[cap_cnt] and increment cap_cnt. Bubbles propagate as invalid entries and are not captured.
- DRAIN: prd_ready_o = 0 and sbox_valid_o = 0. Stay until cap_cnt reaches NBYTES, then go to DONE. Capture may also complete while still in ISSUE when LATENCY is small; go to DONE only when both counters have reached NBYTES.
- DONE:
  - out_valid_o = 1; data_o and mask_o hold stable.
  - On out_ready_i, go to IDLE. out_valid_o drops on the next edge, and in_ready_o rises on the same edge.
  - No new word is accepted in the same cycle as the output handshake.
- Latency with no prd stalls: the result is valid NBYTES + LATENCY edges after the accept edge (7 with the defaults). Each prd stall cycle adds 1.
- sbox_op_o is held constant from accept until return to IDLE.
- Outside DONE, data_o and mask_o show the partially filled result register; consumers use them only while out_valid_o is high.
- A simultaneous in_valid_i and out_ready_i in any state other than IDLE/DONE is ignored.

Optional Feature:
- Macro: MASKED_SCHED_ZEROIZE_EN.
- With the macro defined: on the DONE-to-IDLE edge, the latched input shares and the result registers clear to 0, so data_o and mask_o read 0 in IDLE.
- Without the macro: the registers retain the last word until overwritten, and data_o/mask_o keep the last result after the handshake.

Test Plan:
- Bench uses a behavioural masked S-box model with LATENCY=3 and forward op.
- Basic word: data_i=0x00000000, mask_i=0x00000000, prd always valid -> out_valid_o high 7 edges after accept; data_o^mask_o=0x63636363.
- Masked word: data_i=0x00112233, mask_i=0xA5A5A5A5 -> data_o^mask_o=0x068D1790; sbox_prd_o shows 4 distinct consecutive prd_i bytes.
- prd stalls: prd_valid_i low for 2 cycles after byte 1 -> two bubbles with sbox_valid_o=0 and zero buses; result correct; out_valid_o at 9 edges after accept.
- Output backpressure: out_ready_i held low for 5 cycles -> out_valid_o, data_o and mask_o stable throughout; in_ready_o stays low until the handshake edge.
- Reset mid-DRAIN: assert rst_i asynchronously -> all outputs 0 and in_ready_o=1 immediately; the next word completes correctly with no stale captures.
- Zeroize: build with MASKED_SCHED_ZEROIZE_EN -> data_o=mask_o=0 one edge after the handshake; build without it -> values persist.

Source files
------------

// File: rtl/masked_sbox_sched_if.sv
// Word-side bundle of the masked S-box scheduler: input word handshake,
// result word handshake and busy flag.
interface masked_sbox_sched_if #(
    parameter int NBYTES = 4
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [0:8*NBYTES-1]   data_i;
    logic [0:8*NBYTES-1]   mask_i;
    logic [0:1]            op_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [0:8*NBYTES-1]   data_o;
    logic [0:8*NBYTES-1]   mask_o;
    logic                  busy_o;

    modport slave (
        input  in_valid_i, data_i, mask_i, op_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, mask_o, busy_o
    );

    modport master (
        output in_valid_i, data_i, mask_i, op_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, mask_o, busy_o
    );
endinterface

// File: rtl/masked_sbox_sched.sv
// Feeds one two-share word byte-by-byte through a shared pipelined masked S-box.
// Optional MASKED_SCHED_ZEROIZE_EN clears latched shares and results on output handshake.
//
//   state | meaning
//   IDLE  | ready for a new word
//   ISSUE | issuing one byte per cycle that has a fresh random byte
//   DRAIN | all bytes issued, waiting for the last S-box returns
//   DONE  | result word presented, waiting for out_ready_i
module masked_sbox_sched #(
    parameter int NBYTES  = 4,
    parameter int LATENCY = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    masked_sbox_sched_if.slave   bus,
    input  logic [0:7]           prd_i,
    input  logic                 prd_valid_i,
    output logic                 prd_ready_o,
    output logic                 sbox_valid_o,
    output logic [0:7]           sbox_data_o,
    output logic [0:7]           sbox_mask_o,
    output logic [0:1]           sbox_op_o,
    output logic [0:7]           sbox_prd_o,
    input  logic [0:7]           sbox_data_i,
    input  logic [0:7]           sbox_mask_i
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] N_FULL = CW'(NBYTES);
    localparam logic [CW-1:0] N_LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [0:NBYTES-1][0:7]     r_data_in;
    logic [0:NBYTES-1][0:7]     r_mask_in;
    logic [0:NBYTES-1][0:7]     r_res_data;
    logic [0:NBYTES-1][0:7]     r_res_mask;
    logic [0:1]                 r_op;
    logic [CW-1:0]              r_issue_cnt;
    logic [CW-1:0]              r_cap_cnt;
    logic [LATENCY-1:0]         r_vpipe;
    logic                       r_sbox_valid;
    logic [0:7]                 r_sbox_data;
    logic [0:7]                 r_sbox_mask;
    logic [0:7]                 r_sbox_prd;

    logic                       w_accept;
    logic                       w_issue;
    logic                       w_cap;
    logic                       w_out_hs;
    logic                       w_issue_done;
    logic                       w_cap_done;
    logic [0:7]                 w_cur_data;
    logic [0:7]                 w_cur_mask;

    assign w_accept     = (r_state == IDLE) && bus.in_valid_i;
    assign w_issue      = (r_state == ISSUE) && prd_valid_i;
    assign w_cap        = r_vpipe[LATENCY-1];
    assign w_out_hs     = (r_state == DONE) && bus.out_ready_i;
    // "done" includes the count reached on this very edge
    assign w_issue_done = (r_issue_cnt == N_FULL) || (w_issue && (r_issue_cnt == N_LAST));
    assign w_cap_done   = (r_cap_cnt == N_FULL) || (w_cap && (r_cap_cnt == N_LAST));

    always_comb begin
        w_cur_data = '0;
        w_cur_mask = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_issue_cnt == CW'(k)) begin
                w_cur_data = r_data_in[k];
                w_cur_mask = r_mask_in[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        bus.busy_o      = 1'b1;
        prd_ready_o     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready_o = 1'b1;
                bus.busy_o     = 1'b0;
                if (w_accept) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                prd_ready_o = 1'b1;
                if (w_issue_done && w_cap_done) w_state_nxt = DONE;
                else if (w_issue_done)          w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_issue_done && w_cap_done) w_state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid_o = 1'b1;
                if (w_out_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data_in    <= '0;
            r_mask_in    <= '0;
            r_op         <= '0;
            r_issue_cnt  <= '0;
            r_cap_cnt    <= '0;
            r_vpipe      <= '0;
            r_sbox_valid <= 1'b0;
            r_sbox_data  <= '0;
            r_sbox_mask  <= '0;
            r_sbox_prd   <= '0;
            r_res_data   <= '0;
            r_res_mask   <= '0;
        end else begin
            if (w_accept) begin
                r_data_in   <= bus.data_i;
                r_mask_in   <= bus.mask_i;
                r_op        <= bus.op_i;
                r_issue_cnt <= '0;
                r_cap_cnt   <= '0;
            end else begin
                if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
                if (w_cap)   r_cap_cnt   <= r_cap_cnt + 1'b1;
            end

            // bubbles drive zeros so no share lingers on the S-box bus
            r_sbox_valid <= w_issue;
            r_sbox_data  <= w_issue ? w_cur_data : 8'h00;
            r_sbox_mask  <= w_issue ? w_cur_mask : 8'h00;
            r_sbox_prd   <= w_issue ? prd_i      : 8'h00;

            r_vpipe[0] <= w_issue;
            for (int i = 1; i < LATENCY; i++) r_vpipe[i] <= r_vpipe[i-1];

            for (int k = 0; k < NBYTES; k++) begin
                if (w_cap && (r_cap_cnt == CW'(k))) begin
                    r_res_data[k] <= sbox_data_i;
                    r_res_mask[k] <= sbox_mask_i;
                end
            end

`ifdef MASKED_SCHED_ZEROIZE_EN
            if (w_out_hs) begin
                r_data_in  <= '0;
                r_mask_in  <= '0;
                r_res_data <= '0;
                r_res_mask <= '0;
            end
`else
`endif
        end
    end

    assign sbox_valid_o = r_sbox_valid;
    assign sbox_data_o  = r_sbox_data;
    assign sbox_mask_o  = r_sbox_mask;
    assign sbox_prd_o   = r_sbox_prd;
    assign sbox_op_o    = r_op;
    assign bus.data_o   = r_res_data;
    assign bus.mask_o   = r_res_mask;

endmodule

// File: tb/tb_masked_sbox_sched.sv
// Scoreboard bench for masked_sbox_sched with a behavioural masked AES S-box
// (LATENCY=3, output mask share = the random byte used for that call).
module tb_masked_sbox_sched;

    localparam int NB = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef struct { logic [31:0] word; int lat; } res_t;
    typedef struct { logic [7:0] d; logic [7:0] m; logic [1:0] op; } byte_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [0:7] prd_i;
    logic prd_valid_i;
    logic prd_ready_o;
    logic sbox_valid_o;
    logic [0:7] sbox_data_o, sbox_mask_o, sbox_prd_o;
    logic [0:1] sbox_op_o;
    logic [0:7] sbox_data_i, sbox_mask_i;

    masked_sbox_sched_if #(.NBYTES(NB)) u_if ();

    masked_sbox_sched #(.NBYTES(NB), .LATENCY(3)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (u_if),
        .prd_i       (prd_i),
        .prd_valid_i (prd_valid_i),
        .prd_ready_o (prd_ready_o),
        .sbox_valid_o(sbox_valid_o),
        .sbox_data_o (sbox_data_o),
        .sbox_mask_o (sbox_mask_o),
        .sbox_op_o   (sbox_op_o),
        .sbox_prd_o  (sbox_prd_o),
        .sbox_data_i (sbox_data_i),
        .sbox_mask_i (sbox_mask_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int prd_taken = 0;
    int gap_at   = -1;
    int gap_len  = 0;

    res_t       rq[$];
    byte_t      bq[$];
    logic [7:0] pq[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // S-box model: two register stages after the scheduler's issue register
    logic [7:0] sp_d [2];
    logic [7:0] sp_m [2];
    logic [7:0] sp_p [2];
    always @(posedge clk_i) begin
        sp_d[0] <= sbox_data_o;  sp_m[0] <= sbox_mask_o;  sp_p[0] <= sbox_prd_o;
        sp_d[1] <= sp_d[0];      sp_m[1] <= sp_m[0];      sp_p[1] <= sp_p[0];
    end
    assign sbox_data_i = SBOX[sp_d[1] ^ sp_m[1]] ^ sp_p[1];
    assign sbox_mask_i = sp_p[1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {u_if.in_ready_o, u_if.out_valid_o, u_if.busy_o, prd_ready_o, sbox_valid_o,
                     sbox_op_o, sbox_data_o, sbox_mask_o, sbox_prd_o, u_if.data_o, u_if.mask_o},
              {1'b1, 94'd0});
    endtask

    // random-byte source with optional stall window
    initial begin
        logic take;
        prd_i = 8'h5A;
        prd_valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            take = prd_valid_i && prd_ready_o && !rst_i;
            if (take) pq.push_back(prd_i);
            @(posedge clk_i);
            #1;
            if (take) begin
                prd_i = prd_i + 8'h35;
                prd_taken++;
            end
            if (prd_taken == gap_at && gap_len > 0) begin
                prd_valid_i = 1'b0;
                gap_len--;
            end else begin
                prd_valid_i = 1'b1;
            end
        end
    end

    // S-box bus monitor
    initial begin
        byte_t b;
        logic [7:0] p;
        forever begin
            @(negedge clk_i);
            if (rst_i) continue;
            if (sbox_valid_o) begin
                check("issue_expected", bq.size() > 0, 1'b1);
                check("prd_expected", pq.size() > 0, 1'b1);
                if (bq.size() > 0) begin
                    b = bq.pop_front();
                    check("sbox_data", sbox_data_o, b.d);
                    check("sbox_mask", sbox_mask_o, b.m);
                    check("sbox_op", sbox_op_o, b.op);
                end
                if (pq.size() > 0) begin
                    p = pq.pop_front();
                    check("sbox_prd", sbox_prd_o, p);
                end
            end else if (u_if.busy_o) begin
                check("bubble_zero", {sbox_data_o, sbox_mask_o, sbox_prd_o}, 24'd0);
            end
        end
    end

    // result monitor
    initial begin
        res_t cur;
        bit have_cur = 0;
        bit ov_prev = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                ov_prev = 0;
                have_cur = 0;
                continue;
            end
            if (u_if.out_valid_o && !ov_prev) begin
                check("result_pending", rq.size() > 0, 1'b1);
                if (rq.size() > 0) begin
                    cur = rq.pop_front();
                    have_cur = 1;
                    check("latency", cyc - acc_cyc, cur.lat);
                end
            end
            if (u_if.out_valid_o && have_cur)
                check("result_word", u_if.data_o ^ u_if.mask_o, cur.word);
            if (u_if.out_valid_o) check("in_ready_low_in_done", u_if.in_ready_o, 1'b0);
            ov_prev = u_if.out_valid_o;
        end
    end

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (u_if.in_ready_o && rq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] m, input logic [1:0] op,
                        input logic [31:0] expw, input int lat);
        res_t r;
        byte_t b;
        @(posedge clk_i);
        #1;
        u_if.in_valid_i = 1'b1;
        u_if.data_i = d;
        u_if.mask_i = m;
        u_if.op_i = op;
        for (int k = 0; k < NB; k++) begin
            b.d = d[31-8*k -: 8];
            b.m = m[31-8*k -: 8];
            b.op = op;
            bq.push_back(b);
        end
        r.word = expw;
        r.lat = lat;
        rq.push_back(r);
        @(posedge clk_i);
        #1;
        u_if.in_valid_i = 1'b0;
        acc_cyc = cyc;
        check("accepted", u_if.busy_o, 1'b1);
    endtask

    task automatic check_after_handshake(input string name, input logic [31:0] last_word);
`ifdef MASKED_SCHED_ZEROIZE_EN
        check(name, {u_if.data_o, u_if.mask_o}, 64'd0);
`else
        check(name, u_if.data_o ^ u_if.mask_o, last_word);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_i = 1'b1;
        u_if.in_valid_i = 1'b0;
        u_if.data_i = '0;
        u_if.mask_i = '0;
        u_if.op_i = '0;
        u_if.out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset_state");
        rst_i = 1'b0;

        // all-zero word
        send(32'h0000_0000, 32'h0000_0000, 2'b00, 32'h6363_6363, 7);
        wait_idle("basic_done");

        // masked word
        send(32'h0011_2233, 32'hA5A5_A5A5, 2'b01, 32'h068D_1790, 7);
        wait_idle("masked_done");
        check_after_handshake("keep_or_zero_masked", 32'h068D_1790);

        // random stream stalls for two cycles after byte 1
        gap_at = prd_taken + 2;
        gap_len = 2;
        send(32'h0011_2233, 32'hA5A5_A5A5, 2'b10, 32'h068D_1790, 9);
        wait_idle("stall_done");

        // output backpressure with a competing input word held valid
        u_if.out_ready_i = 1'b0;
        send(32'h1133_5577, 32'h1010_1010, 2'b11, 32'h7C26_6E85, 7);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (u_if.out_valid_o) begin
                seen = 1;
                break;
            end
        end
        check("bp_out_valid_seen", seen, 1'b1);
        @(posedge clk_i);
        #1;
        u_if.in_valid_i = 1'b1;
        u_if.data_i = 32'hFFFF_FFFF;
        u_if.mask_i = 32'h0;
        repeat (5) begin
            @(negedge clk_i);
            check("bp_hold_valid", u_if.out_valid_o, 1'b1);
        end
        @(posedge clk_i);
        #1;
        u_if.out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        u_if.in_valid_i = 1'b0;
        check("bp_after_hs", {u_if.in_ready_o, u_if.out_valid_o, u_if.busy_o}, 3'b100);
        check_after_handshake("keep_or_zero_bp", 32'h7C26_6E85);
        @(negedge clk_i);
        check("bp_no_accept", u_if.busy_o, 1'b0);

        // asynchronous reset while draining
        send(32'h0011_2233, 32'hA5A5_A5A5, 2'b01, 32'h068D_1790, 7);
        repeat (5) @(posedge clk_i);
        #3;
        check("pre_reset_drain", {u_if.busy_o, prd_ready_o, u_if.out_valid_o}, 3'b100);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        rq.delete();
        bq.delete();
        pq.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("held_reset");
        rst_i = 1'b0;

        send(32'h0123_4567, 32'h0000_0000, 2'b10, 32'h7C26_6E85, 7);
        wait_idle("post_reset_done");
        check_after_handshake("keep_or_zero_final", 32'h7C26_6E85);
        check("queues_drained", {rq.size() == 0, bq.size() == 0, pq.size() == 0}, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
